// File: rtl/dot_matrix_scanner_if.sv
// Control/pixel bundle between game logic and the dot matrix scanner.
// master drives control and glyph writes, slave drives the matrix pins.
interface dot_matrix_scanner_if #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int NUM_GLYPHS = 4
);
    localparam int GW = $clog2(NUM_GLYPHS);
    localparam int RW = $clog2(ROWS);

    logic            scan_en;
    logic [GW-1:0]   glyph_sel;
    logic            glyph_load;
    logic            blink_en;
    logic            wr_en;
    logic [GW-1:0]   wr_glyph;
    logic [RW-1:0]   wr_row;
    logic [COLS-1:0] wr_data;
    logic [ROWS-1:0] dot_row;
    logic [COLS-1:0] dot_col;
    logic            frame_done;
    logic [GW-1:0]   active_glyph;

    modport master (
        output scan_en, glyph_sel, glyph_load, blink_en,
        output wr_en, wr_glyph, wr_row, wr_data,
        input  dot_row, dot_col, frame_done, active_glyph
    );

    modport slave (
        input  scan_en, glyph_sel, glyph_load, blink_en,
        input  wr_en, wr_glyph, wr_row, wr_data,
        output dot_row, dot_col, frame_done, active_glyph
    );
endinterface

// File: rtl/dot_matrix_scanner.sv
// Row-scanning LED matrix driver with writable glyph RAM, frame-aligned
// glyph switching and optional frame-counted blink.
module dot_matrix_scanner #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int NUM_GLYPHS   = 4,
    parameter int BLINK_FRAMES = 32
) (
    input logic                 clk_div,
    input logic                 rst,
    dot_matrix_scanner_if.slave bus
);
    localparam int GW = $clog2(NUM_GLYPHS);
    localparam int RW = $clog2(ROWS);
    localparam int FW = 8;
    localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(BLINK_FRAMES - 1);

    logic [COLS-1:0] ram_q [NUM_GLYPHS][ROWS];

    logic [ROWS-1:0] dot_row_q, dot_row_d;
    logic [COLS-1:0] dot_col_q, dot_col_d;
    logic            frame_done_q, frame_done_d;
    logic [GW-1:0]   active_q, active_d;
    logic [GW-1:0]   pending_q, pending_d;
    logic [RW-1:0]   row_q, row_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            hidden_q, hidden_d;

    logic load_ok;
    logic wr_ok;
    logic last_row;

    assign load_ok = bus.glyph_load &&
                     ({1'b0, bus.glyph_sel} < (GW+1)'(NUM_GLYPHS));
    assign wr_ok   = bus.wr_en &&
                     ({1'b0, bus.wr_glyph} < (GW+1)'(NUM_GLYPHS)) &&
                     ({1'b0, bus.wr_row} < (RW+1)'(ROWS));
    assign last_row = (row_q == LAST_ROW);

    always_comb begin
        dot_row_d    = dot_row_q;
        dot_col_d    = dot_col_q;
        frame_done_d = 1'b0;
        active_d     = active_q;
        pending_d    = pending_q;
        row_d        = row_q;
        fcnt_d       = fcnt_q;
        hidden_d     = hidden_q;

        if (load_ok) begin
            pending_d = bus.glyph_sel;
        end

        if (bus.scan_en) begin
            // Row r maps to bit ROWS-1-r, driven low.
            dot_row_d = ~(ROWS'(1) << (LAST_ROW - row_q));
            dot_col_d = (bus.blink_en && hidden_q) ? '0
                                                   : ram_q[active_q][row_q];
            row_d     = last_row ? '0 : row_q + RW'(1);
            if (last_row) begin
                frame_done_d = 1'b1;
                // A load in the boundary cycle bypasses pending.
                active_d     = load_ok ? bus.glyph_sel : pending_q;
                if (fcnt_q == LAST_FRAME) begin
                    fcnt_d   = '0;
                    hidden_d = ~hidden_q;
                end else begin
                    fcnt_d   = fcnt_q + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_div) begin
        if (rst) begin
            dot_row_q    <= '1;
            dot_col_q    <= '0;
            frame_done_q <= 1'b0;
            active_q     <= '0;
            pending_q    <= '0;
            row_q        <= '0;
            fcnt_q       <= '0;
            hidden_q     <= 1'b0;
        end else begin
            dot_row_q    <= dot_row_d;
            dot_col_q    <= dot_col_d;
            frame_done_q <= frame_done_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            row_q        <= row_d;
            fcnt_q       <= fcnt_d;
            hidden_q     <= hidden_d;
        end
    end

    always_ff @(posedge clk_div) begin
        if (rst) begin
            for (int g = 0; g < NUM_GLYPHS; g++) begin
                for (int r = 0; r < ROWS; r++) begin
                    ram_q[g][r] <= '0;
                end
            end
        end else if (wr_ok) begin
            ram_q[bus.wr_glyph][bus.wr_row] <= bus.wr_data;
        end
    end

    assign bus.dot_row      = dot_row_q;
    assign bus.dot_col      = dot_col_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.active_glyph = active_q;
endmodule
